pc_seg7_scan: RTL and testbench

Multiplexed 4-digit 7-segment scanner that consumes the 16-bit 6502 `pc_monitor` bus exported by the Apple 1 core and drives the EP4CE6 board's common-anode display. It replaces the per-digit static decoders with one scanned output path. The block runs in the 25 MHz system domain, samples the address at a human-readable rate, and applies the new value only at frame boundaries so the display never tears.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/hex7seg_decode.sv | 12 +
 rtl/pc_seg7_scan.sv | 151 +++++++++++++++
 tb/tb_pc_seg7_scan.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment display path.
// Holds the hex glyph table, the scan state type and the digit count.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Nibble to active-high 7-segment glyph.
// Purely combinational; polarity is handled by the caller.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/pc_seg7_scan.sv
// Multiplexed 4-digit scanner for the 6502 pc_monitor bus.
// Samples slowly, swaps the shown value only at frame wrap.
module pc_seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 6250,
  parameter int BLANK_CYCLES   = 250,
  parameter int SAMPLE_DIV     = 2500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        hold,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  dig_out,
  output logic        frame_tick
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SAMPLE_DIV);

  localparam logic [RW-1:0] SLOT_LAST =
    RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] BLANK_LAST =
    RW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SAMPLE_LAST =
    SW'(SAMPLE_DIV - 1);
  localparam logic [1:0] IDX_LAST =
    2'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [3:0] DIG_OFF =
    DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  scan_state_t   state;
  logic [RW-1:0] slot;
  logic [1:0]    idx;
  logic [SW-1:0] scnt;

  logic [15:0] pend_val;
  logic [3:0]  pend_dp;
  logic        pend_valid;
  logic [15:0] disp_val;
  logic [3:0]  disp_dp;

  logic       sample_wrap;
  logic       slot_end;
  logic       frame_wrap;
  logic       blank_end;
  logic       seg_load;
  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic [3:0] dig_on;

  assign sample_wrap = (scnt == SAMPLE_LAST);
  assign slot_end    = (state == ON) &&
                       (slot == SLOT_LAST);
  assign frame_wrap  = slot_end && (idx == IDX_LAST);
  assign blank_end   = (state == BLANK) &&
                       ((BLANK_CYCLES == 0) ||
                        (slot == BLANK_LAST));

  // Without blanking the glyph must still reload at slot start
  assign seg_load = (state == BLANK) ||
                    ((BLANK_CYCLES == 0) && (slot == '0));

  assign cur_nib = disp_val[{idx, 2'b00} +: 4];
  assign dig_on  = 4'b0001 << idx;

  hex7seg_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // A sample landing on the wrap cycle becomes the next pending value
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      scnt       <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      scnt <= sample_wrap ? '0 : scnt + SW'(1);
      if (frame_wrap && pend_valid) begin
        disp_val   <= pend_val;
        disp_dp    <= pend_dp;
        pend_valid <= 1'b0;
      end
      if (sample_wrap && !hold) begin
        pend_val   <= value_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state <= BLANK;
      slot  <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        BLANK: begin
          slot <= slot + RW'(1);
          if (blank_end) begin
            state <= ON;
          end
        end
        ON: begin
          if (slot_end) begin
            slot  <= '0;
            idx   <= idx + 2'd1;
            state <= (BLANK_CYCLES == 0) ? ON : BLANK;
          end else begin
            slot <= slot + RW'(1);
          end
        end
        default: begin
          state <= BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      seg_out    <= SEG_OFF;
      dp_out     <= DP_OFF;
      dig_out    <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      dig_out    <= (state == ON) ?
                    (dig_on ^ DIG_OFF) : DIG_OFF;
      if (seg_load) begin
        seg_out <= dec_seg ^ SEG_OFF;
        dp_out  <= disp_dp[idx] ^ DP_OFF;
      end
    end
  end

endmodule

// File: tb/tb_pc_seg7_scan.sv
// Scoreboard bench for pc_seg7_scan with small scan parameters.
// A frame-level model predicts the shown value; a monitor checks pins.
module tb_pc_seg7_scan;

  localparam int R  = 50;
  localparam int B  = 5;
  localparam int S  = 100;
  localparam int FR = 4 * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig;
  logic       ft;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] dig_d;
  logic       ft_d;

  always #20 clk = ~clk;

  pc_seg7_scan #(
    .REFRESH_DIV    (R),
    .BLANK_CYCLES   (B),
    .SAMPLE_DIV     (S),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) u_dut (
    .clk25      (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .hold       (hold),
    .dp_in      (dp_in),
    .seg_out    (seg),
    .dp_out     (dp),
    .dig_out    (dig),
    .frame_tick (ft)
  );

  pc_seg7_scan u_def (
    .clk25      (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .hold       (hold),
    .dp_in      (dp_in),
    .seg_out    (seg_d),
    .dp_out     (dp_d),
    .dig_out    (dig_d),
    .frame_tick (ft_d)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;
      4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;
      4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Frame-level reference: edge count since release drives events
  int unsigned n;
  logic [19:0] m_pend;
  logic [19:0] m_disp;
  bit          m_pv;
  logic [19:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      m_pv = 0;
      m_pend = '0;
      m_disp = '0;
      exp_q.delete();
    end else begin
      n++;
      if (n % FR == 0) begin
        if (m_pv) begin
          m_disp = m_pend;
          m_pv = 0;
        end
        exp_q.push_back(m_disp);
      end
      if (n % S == 0 && !hold) begin
        m_pend = {dp_in, value_in};
        m_pv = 1;
      end
    end
  end

  logic [19:0] cur;
  logic [19:0] nxt;
  bit          nxt_ok;
  int          run;
  int          frames = 0;
  logic [6:0]  prev_seg;
  logic [3:0]  prev_dig;
  logic [7:0]  shown [4];

  always @(negedge clk) begin
    int d;
    bit tick_due;
    if (!rst_n) begin
      cur = '0;
      nxt_ok = 0;
      run = 0;
      for (int i = 0; i < 4; i++) shown[i] = 8'hFF;
    end else begin
      tick_due = (n != 0) && (n % FR == 0);
      if (ft || tick_due) chk("frame_tick", ft, tick_due);
      if (ft) begin
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          nxt = exp_q.pop_front();
          nxt_ok = 1;
          frames++;
        end
      end
      if (seg !== prev_seg) chk("blank_rule", dig, 4'hF);
      if (dig != 4'hF) begin
        if (prev_dig == 4'hF) begin
          case (dig)
            4'hE: d = 0;
            4'hD: d = 1;
            4'hB: d = 2;
            4'h7: d = 3;
            default: d = -1;
          endcase
          if (d < 0) begin
            chk("dig_onehot", dig, 4'hE);
          end else begin
            if (d == 0 && nxt_ok) begin
              cur = nxt;
              nxt_ok = 0;
            end
            chk("digit_glyph", {~dp, ~seg},
                {cur[16+d], glyph(cur[4*d +: 4])});
            shown[d] = {~dp, ~seg};
          end
        end
        run++;
      end else if (run != 0) begin
        chk("on_len", run, R - B);
        run = 0;
      end
    end
    prev_seg = seg;
    prev_dig = dig;
  end

  task automatic expect_shown(input string name,
                              input logic [15:0] v);
    for (int i = 0; i < 4; i++)
      chk(name, shown[i], {1'b0, glyph(v[4*i +: 4])});
  endtask

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit all_f;
    value_in = 16'hA1F0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dig", dig, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_tick", ft, 1'b0);
    chk("rst_def_dig", dig_d, 4'hF);
    chk("rst_def_seg", seg_d, 7'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (dig_d !== 4'hE && k < 400);
    chk("first_enable_cycle", k, 251);

    repeat (400) @(negedge clk);
    expect_shown("basic_a1f0", 16'hA1F0);

    value_in = 16'h1234;
    repeat (600) @(negedge clk);
    expect_shown("pre_1234", 16'h1234);
    k = 0;
    while (!ft && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("tick_seen", ft, 1'b1);
    repeat (2 * R) @(negedge clk);
    value_in = 16'h5678;
    repeat (600) @(negedge clk);
    expect_shown("post_5678", 16'h5678);

    hold = 1'b1;
    value_in = 16'hFFFF;
    repeat (10 * S) @(negedge clk);
    expect_shown("held_5678", 16'h5678);
    hold = 1'b0;
    k = 0;
    all_f = 0;
    while (!all_f && k < S + 8 * R + 2) begin
      @(negedge clk);
      k++;
      all_f = 1;
      for (int i = 0; i < 4; i++)
        if (shown[i] != 8'h71) all_f = 0;
    end
    chk("hold_release_ffff", all_f, 1'b1);

    for (int it = 0; it < 40; it++) begin
      value_in = 16'($urandom);
      dp_in = 4'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 300)) @(negedge clk);
    end
    hold = 1'b0;
    repeat (2 * FR) @(negedge clk);

    k = 0;
    while (dig !== 4'hB && k < 2 * FR) begin
      @(negedge clk);
      k++;
    end
    chk("reach_digit2", dig, 4'hB);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_dig", dig, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dp", dp, 1'b1);
    chk("mid_rst_tick", ft, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (dig === 4'hF && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("restart_digit0", dig, 4'hE);
    repeat (170) @(negedge clk);
    expect_shown("after_rst_0000", 16'h0000);

    repeat (FR) @(negedge clk);
    chk("frames_seen", frames > 20, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
